// File: rtl/uart_key_lock_pkg.sv
// Shared types and sizing helpers for the UART key lock.
// Checker and receiver state encodings live here.
package uart_key_lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PASS,
        FAIL,
        LOCKED
    } chk_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int BYTE_W = 8;
    localparam int BIT_IDX_W = 3;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser.
// Emits one-cycle strobes for a good byte or a bad stop bit.
module uart_rx
    import uart_key_lock_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int CW = cnt_w(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 line_q;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BYTE_W-1:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            line_q    <= 1'b0;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync1     <= uart;
            sync2     <= sync1;
            line_q    <= sync2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    // Falling edge only, so a low line after a bad
                    // stop bit cannot retrigger a frame.
                    if (line_q && !sync2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[BYTE_W-1:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync2) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_key_lock.sv
// UART-fed key lock: scores KEY_LEN-byte attempts against KEY,
// drives pass/fail LEDs and locks out after repeated failures.
module uart_key_lock
    import uart_key_lock_pkg::*;
#(
    parameter int                  CLKS_PER_BIT   = 1042,
    parameter int                  KEY_LEN        = 4,
    parameter logic [KEY_LEN*8-1:0] KEY           = 32'h7470_6d21,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  RED_HOLD       = 5_000_000,
    parameter int                  LOCKOUT_CYCLES = 100_000_000,
    parameter int                  TIMEOUT_CYCLES = 20_000_000
) (
    input  logic                          wb_clk_i,
    input  logic                          rst_n,
    input  logic                          uart,
    output logic                          led_green,
    output logic                          led_red,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic                          frame_err
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int IW = cnt_w(KEY_LEN - 1);
    localparam int TM1 = (RED_HOLD > LOCKOUT_CYCLES) ? RED_HOLD : LOCKOUT_CYCLES;
    localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
    localparam int TW = cnt_w(TMAX);

    localparam logic [IW-1:0] IDX_LAST  = IW'(KEY_LEN - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] T_RED     = TW'(RED_HOLD - 1);
    localparam logic [TW-1:0] T_LOCK    = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_TO      = TW'(TIMEOUT_CYCLES - 1);

    chk_state_t        state;
    logic [IW-1:0]     idx;
    logic              mm;
    logic [TW-1:0]     tmr;
    logic [BYTE_W-1:0] key_byte;
    logic              mm_next;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .uart     (uart),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    always_comb begin
        key_byte = '0;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (idx == IW'(i)) key_byte = KEY[i*8 +: 8];
        end
        mm_next = mm | (rx_data != key_byte);
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            mm         <= 1'b0;
            tmr        <= '0;
            led_green  <= 1'b0;
            led_red    <= 1'b0;
            locked     <= 1'b0;
            fail_count <= '0;
        end else begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (frame_err) begin
                        idx   <= '0;
                        mm    <= 1'b0;
                        tmr   <= '0;
                        state <= IDLE;
                    end else if (rx_valid) begin
                        tmr <= '0;
                        if (idx == IDX_LAST) begin
                            // Every byte is consumed before scoring so the
                            // first wrong position is never revealed.
                            idx <= '0;
                            mm  <= 1'b0;
                            if (!mm_next) begin
                                state      <= PASS;
                                led_green  <= 1'b1;
                                fail_count <= '0;
                            end else if (fail_count == FAIL_LAST) begin
                                state      <= LOCKED;
                                fail_count <= FAIL_MAX;
                                led_red    <= 1'b1;
                                locked     <= 1'b1;
                            end else begin
                                state      <= FAIL;
                                fail_count <= fail_count + 1'b1;
                                led_red    <= 1'b1;
                            end
                        end else begin
                            idx   <= idx + 1'b1;
                            mm    <= mm_next;
                            state <= COLLECT;
                        end
                    end else if (state == COLLECT && idx != '0) begin
                        if (tmr == T_TO) begin
                            idx   <= '0;
                            mm    <= 1'b0;
                            tmr   <= '0;
                            state <= IDLE;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                end
                FAIL: begin
                    if (tmr == T_RED) begin
                        led_red <= 1'b0;
                        tmr     <= '0;
                        state   <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                LOCKED: begin
                    if (tmr == T_LOCK) begin
                        led_red    <= 1'b0;
                        locked     <= 1'b0;
                        fail_count <= '0;
                        tmr        <= '0;
                        state      <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                PASS: begin
                    state <= PASS;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
